// File: rtl/md5_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : md5_pkg                                                      |
// | Description : Shared constants and helpers for the MD5 digest matcher:     |
// |               initial chaining values, bus widths and the word byte swap   |
// |               that turns little-endian state words into digest byte order. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package md5_pkg;

    // MD5 initial chaining values, added back to the state after operation 63.
    localparam logic [31:0] A0 = 32'h67452301;
    localparam logic [31:0] B0 = 32'hEFCDAB89;
    localparam logic [31:0] C0 = 32'h98BADCFE;
    localparam logic [31:0] D0 = 32'h10325476;

    localparam int MSG_W    = 512;
    localparam int DIGEST_W = 128;

    // MD5 emits each state word least-significant byte first; reversing the
    // bytes puts the first digest byte in the top lane.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/match_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : match_fifo                                                   |
// | Description : Synchronous FIFO holding matched messages.                   |
// |               Ports: clk, reset_n (async, active-low), clr (sync flush),   |
// |               push/din, pop/dout, full, empty.                             |
// |               dout reads 0 whenever the FIFO is empty. A push into a full  |
// |               FIFO succeeds only when a pop happens on the same edge.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module match_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] c_depth_cnt = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_do_pop;
    logic w_do_push;

    assign full  = (r_count == c_depth_cnt);
    assign empty = (r_count == '0);

    // When full, the slot being written is the one being read out this edge,
    // so a simultaneous push/pop keeps occupancy and order intact.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    assign dout = empty ? '0 : r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is never observed while empty, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_do_push && !clr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/md5_digest_match.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : md5_digest_match                                             |
// | Description : Final stage of an MD5 search pipeline. Adds the chaining     |
// |               values to the op-63 state, compares the resulting digest     |
// |               with a loaded target and queues matching messages.           |
// |               Ports: clk, reset_n (async, active-low), en, in_valid,       |
// |               a/b/c/d (state), m_in (message), tgt_load/tgt_hash (target), |
// |               out_valid/out_msg/out_ready (match queue), match_cnt,        |
// |               overflow.                                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module md5_digest_match
    import md5_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                in_valid,
    input  logic [31:0]         a,
    input  logic [31:0]         b,
    input  logic [31:0]         c,
    input  logic [31:0]         d,
    input  logic [MSG_W-1:0]    m_in,
    input  logic                tgt_load,
    input  logic [DIGEST_W-1:0] tgt_hash,
    output logic                out_valid,
    output logic [MSG_W-1:0]    out_msg,
    input  logic                out_ready,
    output logic [15:0]         match_cnt,
    output logic                overflow
);

    // Stage 1: chaining-value addition (carry out of bit 31 is discarded).
    logic [31:0]         r_sum_a;
    logic [31:0]         r_sum_b;
    logic [31:0]         r_sum_c;
    logic [31:0]         r_sum_d;
    logic [MSG_W-1:0]    r_msg;
    logic                r_v1;
    logic [DIGEST_W-1:0] r_tgt;
    logic [15:0]         r_match_cnt;
    logic                r_overflow;

    logic [DIGEST_W-1:0] w_digest;
    logic                w_hit;
    logic                w_push_req;
    logic                w_pop_req;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_drop;

    always_ff @(posedge clk) begin
        if (en) begin
            r_sum_a <= a + A0;
            r_sum_b <= b + B0;
            r_sum_c <= c + C0;
            r_sum_d <= d + D0;
            r_msg   <= m_in;
        end
    end

    // Loading a new target invalidates whatever is in stage 1 so that a
    // candidate is never judged against a target it was not meant for.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v1 <= 1'b0;
        end else if (tgt_load) begin
            r_v1 <= 1'b0;
        end else if (en) begin
            r_v1 <= in_valid;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tgt <= '0;
        end else if (tgt_load) begin
            r_tgt <= tgt_hash;
        end
    end

    // Stage 2: digest byte order and compare, purely combinational.
    assign w_digest = {bswap32(r_sum_a), bswap32(r_sum_b),
                       bswap32(r_sum_c), bswap32(r_sum_d)};
    assign w_hit    = r_v1 && (w_digest == r_tgt);

    assign w_push_req = en && w_hit && !tgt_load;
    assign w_pop_req  = out_ready && !tgt_load;
    assign w_drop     = w_push_req && w_fifo_full && !(w_pop_req && !w_fifo_empty);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_match_cnt <= '0;
            r_overflow  <= 1'b0;
        end else if (tgt_load) begin
            r_match_cnt <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push_req && (r_match_cnt != 16'hFFFF)) begin
                r_match_cnt <= r_match_cnt + 16'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    match_fifo #(
        .WIDTH (MSG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_match_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (tgt_load),
        .push    (w_push_req),
        .din     (r_msg),
        .pop     (w_pop_req),
        .dout    (out_msg),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    assign out_valid = !w_fifo_empty;
    assign match_cnt = r_match_cnt;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: doc/md5_digest_match.md
MD5_DIGEST_MATCH -- requirements
Module: md5_digest_match

Interface
REQ-001 SHALL have parameter: FIFO_DEPTH, 4, number of matched-message entries buffered (power of 2, >=2).
REQ-002 SHALL have port: clk  input  1  single clock, all logic rising-edge.
REQ-003 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: en  input  1  pipeline advance; 0 holds both stages.
REQ-005 SHALL have port: in_valid  input  1  marks a,b,c,d,m_in as a real candidate (final-op output of the hash pipeline).
REQ-006 SHALL have ports: a, b, c, d  input  32 each  state words after operation 63.
REQ-007 SHALL have port: m_in  input  512  candidate message block travelling with the state.
REQ-008 SHALL have port: tgt_load  input  1  load strobe for tgt_hash.
REQ-009 SHALL have port: tgt_hash  input  128  target digest, standard MD5 byte order (first digest byte in [127:120]).
REQ-010 SHALL have port: out_valid  output  1  FIFO non-empty.
REQ-011 SHALL have port: out_msg  output  512  FIFO head message; 0 when out_valid=0.
REQ-012 SHALL have port: out_ready  input  1  consumer pop request.
REQ-013 SHALL have port: match_cnt  output  16  total matches detected, saturating.
REQ-014 SHALL have port: overflow  output  1  sticky: a match was dropped because FIFO full.

Function
REQ-015 Stage 1 (edge with en=1) SHALL register A=a+A0, B=b+B0, C=c+C0, D=d+D0 (mod 2^32), m_in, and v1=in_valid.
REQ-016 Stage 2 SHALL form digest={bswap(A),bswap(B),bswap(C),bswap(D)}, bswap reversing the four bytes of a word.
REQ-017 hit SHALL be v1 AND (digest == target register), evaluated combinationally from stage-1 registers.
REQ-018 On an edge with en=1 and hit=1, the stage-1 message SHALL be pushed to the FIFO and match_cnt incremented (saturate at 16'hFFFF).
REQ-019 Latency SHALL be 2 en=1 edges from sampling inputs to out_valid=1 (FIFO previously empty).
REQ-020 en=0 SHALL freeze stage-1 registers and suppress push; pop SHALL remain independent of en.
REQ-021 Pop SHALL occur on an edge where out_valid=1 and out_ready=1; out_ready while empty SHALL have no effect.
REQ-022 Push to a full FIFO with simultaneous pop SHALL succeed (occupancy unchanged, order preserved).
REQ-023 Push to a full FIFO without pop SHALL drop the message, set overflow, still increment match_cnt.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; FIFO output order SHALL be strict first-in-first-out.
REQ-025 tgt_load=1 SHALL load tgt_hash, clear v1, empty the FIFO, clear match_cnt and overflow on that edge; it overrides push/pop/en that edge.
REQ-026 Comparison SHALL use the registered target only; new target affects hits from the edge after tgt_load.

Reset
REQ-027 reset_n=0 SHALL asynchronously clear v1, FIFO pointers/count, target register, match_cnt, overflow; out_valid=0, out_msg=0.
REQ-028 Data registers (stage-1 sums, message, FIFO storage) MAY be unreset; no output SHALL expose them while invalid.
REQ-029 Reset deasserted mid-stream SHALL discard all in-flight candidates; first hit possible 2 en edges after release.

Structure
REQ-030 Package md5_pkg SHALL hold A0=32'h67452301, B0=32'hEFCDAB89, C0=32'h98BADCFE, D0=32'h10325476, MSG_W=512, DIGEST_W=128, and the bswap32 function.
REQ-031 FIFO SHALL be a sub-module match_fifo (width, depth parameters, push/pop/full/empty); remainder in md5_digest_match.

Verification
REQ-032 Target 0123456789abcdeffedcba9876543210, a=b=c=d=0, in_valid=1, m_in=512'hA5...A5 -> out_valid=1 after 2nd en edge, out_msg=A5...A5, match_cnt=1.
REQ-033 Same target, a=1 (others 0) -> no push, out_valid stays 0, match_cnt=0.
REQ-034 a=32'h98BADCFF, b=c=d=0, target 0000000089abcdeffedcba9876543210 -> hit (carry discarded), match_cnt=1.
REQ-035 5 consecutive hits, out_ready=0 -> 4 entries, overflow=1, match_cnt=5; then drain 4 pops in input order, out_valid=0, out_msg=0.
REQ-036 FIFO full, hit with out_ready=1 same edge -> occupancy stays 4, overflow stays 0, head advances one entry.
REQ-037 Hit in stage 1 then en=0 for 3 cycles -> no push; reset_n pulsed low mid-stall -> match_cnt=0, out_valid=0, no later push.
